// File: rtl/pass_lock_ctrl.sv
// Password lock controller: edge-triggered confirm/change requests, timed
// open session, and a timed lockout after repeated failed confirms.
module pass_lock_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PASS = 16'h4781,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYCLES = 20,
  parameter int UNLOCK_CYCLES = 50
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               confirmPass,
  input  logic                               changePass,
  input  logic [DIGITS*DIGIT_W-1:0]          password,
  output logic                               right,
  output logic                               error,
  output logic                               locked,
  output logic                               changed,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);

  localparam int PW   = DIGITS * DIGIT_W;
  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN,
    ST_LOCKED
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   pass_reg, pass_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [FW-1:0]   fail_reg, fail_next;
  logic            right_reg, right_next;
  logic            error_reg, error_next;
  logic            locked_reg, locked_next;
  logic            changed_reg, changed_next;
  logic            conf_d_reg, chg_d_reg, armed_reg;

  logic            conf_rise, chg_rise, match;
  logic [FW-1:0]   fail_inc;
  logic [DIGITS-1:0] digit_eq;

  // armed_reg blocks the first edge after reset release, so a level held
  // high across release is absorbed into the edge history, not taken as a request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_d_reg <= 1'b0;
      chg_d_reg  <= 1'b0;
      armed_reg  <= 1'b0;
    end else begin
      conf_d_reg <= confirmPass;
      chg_d_reg  <= changePass;
      armed_reg  <= 1'b1;
    end
  end

  assign conf_rise = armed_reg & confirmPass & ~conf_d_reg;
  // Confirm wins when both requests rise together.
  assign chg_rise  = armed_reg & changePass & ~chg_d_reg & ~conf_rise;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_eq[gi] = (password[gi*DIGIT_W +: DIGIT_W] == pass_reg[gi*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  assign match    = &digit_eq;
  assign fail_inc = (fail_reg == FW'(MAX_TRIES)) ? fail_reg : fail_reg + FW'(1);

  always_comb begin
    state_next   = state_reg;
    pass_next    = pass_reg;
    timer_next   = timer_reg;
    fail_next    = fail_reg;
    right_next   = right_reg;
    error_next   = error_reg;
    locked_next  = locked_reg;
    changed_next = 1'b0;

    case (state_reg)
      ST_LOCKED: begin
        right_next = 1'b0;
        error_next = 1'b1;
        if (timer_reg <= TW'(1)) begin
          state_next  = ST_IDLE;
          timer_next  = '0;
          locked_next = 1'b0;
          error_next  = 1'b0;
          fail_next   = '0;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end

      default: begin
        if (conf_rise) begin
          if (match) begin
            state_next = ST_OPEN;
            right_next = 1'b1;
            error_next = 1'b0;
            fail_next  = '0;
            timer_next = TW'(UNLOCK_CYCLES);
          end else begin
            fail_next  = fail_inc;
            right_next = 1'b0;
            error_next = 1'b1;
            if (fail_inc == FW'(MAX_TRIES)) begin
              state_next  = ST_LOCKED;
              locked_next = 1'b1;
              timer_next  = TW'(LOCK_CYCLES);
            end else begin
              state_next = ST_IDLE;
              timer_next = '0;
            end
          end
        end else if (chg_rise) begin
          if (state_reg == ST_OPEN) begin
            pass_next    = password;
            changed_next = 1'b1;
            state_next   = ST_IDLE;
            right_next   = 1'b0;
            error_next   = 1'b0;
            timer_next   = '0;
          end else begin
            error_next = 1'b1;
          end
        end else if (state_reg == ST_OPEN) begin
          if (timer_reg <= TW'(1)) begin
            state_next = ST_IDLE;
            right_next = 1'b0;
            timer_next = '0;
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      pass_reg    <= DEFAULT_PASS;
      timer_reg   <= '0;
      fail_reg    <= '0;
      right_reg   <= 1'b0;
      error_reg   <= 1'b0;
      locked_reg  <= 1'b0;
      changed_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pass_reg    <= pass_next;
      timer_reg   <= timer_next;
      fail_reg    <= fail_next;
      right_reg   <= right_next;
      error_reg   <= error_next;
      locked_reg  <= locked_next;
      changed_reg <= changed_next;
    end
  end

  assign right    = right_reg;
  assign error    = error_reg;
  assign locked   = locked_reg;
  assign changed  = changed_reg;
  assign fail_cnt = fail_reg;

endmodule

// File: tb/tb_pass_lock_ctrl.sv
// Directed bench for pass_lock_ctrl; expected outputs queued per clock and
// compared one clock later as {right,error,locked,changed,fail_cnt}.
module tb_pass_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        confirmPass = 1'b0;
  logic        changePass = 1'b0;
  logic [15:0] password = 16'h0;
  logic        right, error, locked, changed;
  logic [1:0]  fail_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] sb[$];

  pass_lock_ctrl dut (
    .clk(clk), .rst(rst), .confirmPass(confirmPass), .changePass(changePass),
    .password(password), .right(right), .error(error), .locked(locked),
    .changed(changed), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input logic r, e, l, c, input logic [1:0] f);
    return {r, e, l, c, f};
  endfunction

  task automatic check(input string tag);
    logic [5:0] obs, expv;
    obs  = {right, error, locked, changed, fail_cnt};
    expv = sb.pop_front();
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed r/e/l/c/f=%b expected=%b", tag, obs, expv);
    end
    $display("[%0t] %-14s pw=%h conf=%b chg=%b out=%b", $time, tag, password, confirmPass, changePass, obs);
  endtask

  // Drive one clock of stimulus, queue the outputs expected after the edge.
  task automatic step(input logic conf, chg, input logic [15:0] pw, input logic [5:0] expv, input string tag);
    confirmPass = conf;
    changePass  = chg;
    password    = pw;
    sb.push_back(expv);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    // Reset state
    sb.push_back(ex(0,0,0,0,0));
    #12;
    check("reset");
    @(negedge clk);
    rst = 1'b1;
    step(0,0,16'h0000, ex(0,0,0,0,0), "arm");

    // Correct default password opens the session
    step(1,0,16'h4781, ex(1,0,0,0,0), "open_default");
    step(0,0,16'h4781, ex(1,0,0,0,0), "open_hold");

    // Change password from OPEN
    step(0,1,16'h4102, ex(0,0,0,1,0), "change");
    step(0,0,16'h4102, ex(0,0,0,0,0), "change_pulse");
    step(1,0,16'h4781, ex(0,1,0,0,1), "old_pw_bad");
    step(0,0,16'h4781, ex(0,1,0,0,1), "bad_hold");
    step(1,0,16'h4102, ex(1,0,0,0,0), "new_pw_ok");
    step(0,0,16'h4102, ex(1,0,0,0,0), "open2");

    // Simultaneous confirm/change: confirm (mismatch) wins, no change
    step(1,1,16'h5555, ex(0,1,0,0,1), "simul");
    step(0,0,16'h5555, ex(0,1,0,0,1), "simul_hold");

    // Held confirm yields one request; session times out after 50 clocks
    step(1,0,16'h4102, ex(1,0,0,0,0), "held_open");
    for (int i = 1; i <= 100; i++)
      step(1,0,16'h4102, ex(i < 50, 0,0,0,0), $sformatf("held_%0d", i));
    step(0,0,16'h4102, ex(0,0,0,0,0), "release");

    // Change request in IDLE is rejected
    step(0,1,16'h1234, ex(0,1,0,0,0), "chg_idle");
    step(0,0,16'h1234, ex(0,1,0,0,0), "chg_idle_hold");
    step(1,0,16'h4103, ex(0,1,0,0,1), "one_digit_off");
    step(0,0,16'h4103, ex(0,1,0,0,1), "idle");
    step(1,0,16'h4102, ex(1,0,0,0,0), "mem_unchanged");
    step(0,0,16'h4102, ex(1,0,0,0,0), "idle");

    // Three failed confirms -> lockout for 20 clocks
    step(1,0,16'h0000, ex(0,1,0,0,1), "fail1");
    step(0,0,16'h0000, ex(0,1,0,0,1), "idle");
    step(1,0,16'h0000, ex(0,1,0,0,2), "fail2");
    step(0,0,16'h0000, ex(0,1,0,0,2), "idle");
    step(1,0,16'h0000, ex(0,1,1,0,3), "fail3_lock");
    for (int i = 1; i <= 20; i++) begin
      if (i < 20)
        step(i % 4 == 2, 0, 16'h4102, ex(0,1,1,0,3), $sformatf("lock_%0d", i));
      else
        step(0,0,16'h4102, ex(0,0,0,0,0), "unlock");
    end
    step(1,0,16'h4102, ex(1,0,0,0,0), "post_lock_ok");
    step(0,0,16'h4102, ex(1,0,0,0,0), "idle");

    // Change password, lock, then reset mid-lockout
    step(0,1,16'h9abc, ex(0,0,0,1,0), "change2");
    step(0,0,16'h9abc, ex(0,0,0,0,0), "idle");
    step(1,0,16'h0000, ex(0,1,0,0,1), "f1");
    step(0,0,16'h0000, ex(0,1,0,0,1), "idle");
    step(1,0,16'h0000, ex(0,1,0,0,2), "f2");
    step(0,0,16'h0000, ex(0,1,0,0,2), "idle");
    step(1,0,16'h0000, ex(0,1,1,0,3), "f3_lock");
    step(0,0,16'h0000, ex(0,1,1,0,3), "locked");
    confirmPass = 1'b1;
    password = 16'h4781;
    #2 rst = 1'b0;
    #1;
    sb.push_back(ex(0,0,0,0,0));
    check("async_reset");
    @(negedge clk);
    rst = 1'b1;
    step(1,0,16'h4781, ex(0,0,0,0,0), "held_over_rst");
    step(1,0,16'h4781, ex(0,0,0,0,0), "still_held");
    step(0,0,16'h4781, ex(0,0,0,0,0), "drop");
    step(1,0,16'h4781, ex(1,0,0,0,0), "default_back");
    step(0,0,16'h4781, ex(1,0,0,0,0), "idle");
    step(1,0,16'h9abc, ex(0,1,0,0,1), "lost_change");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
